// File: rtl/fc_pkg.sv
// Shared constants, FSM state type and output rounding/saturation for the
// fully-connected layer engine.
package fc_pkg;

  localparam int unsigned DW    = 20;
  localparam int unsigned FRAC  = 16;
  localparam int unsigned ACC_W = 48;
  localparam int unsigned AW    = 12;
  localparam int unsigned WAW   = 16;

  localparam logic [2:0] CSEL_L5 = 3'b101;
  localparam logic [2:0] CSEL_L6 = 3'b110;

  typedef enum logic [2:0] {
    StIdle,
    StBias,
    StMac,
    StDrain,
    StWrite,
    StDone
  } fc_state_e;

  // Accumulator holds 2*FRAC fractional bits; bring back to FRAC, round half up,
  // then clamp to the signed DW range.
  function automatic logic [DW-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] rnd;
    logic [DW-1:0]           res;
    rnd = acc >>> FRAC;
    rnd = rnd + $signed({{(ACC_W-1){1'b0}}, acc[FRAC-1]});
    if (!rnd[ACC_W-1] && (|rnd[ACC_W-2:DW-1])) begin
      res = {1'b0, {(DW-1){1'b1}}};
    end else if (rnd[ACC_W-1] && !(&rnd[ACC_W-2:DW-1])) begin
      res = {1'b1, {(DW-1){1'b0}}};
    end else begin
      res = rnd[DW-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fc_layer_engine_if.sv
// Control handshake plus layer-memory and weight-ROM port of the FC engine.
// slave: engine side; master: environment (memories, sequencer).
interface fc_layer_engine_if;
  import fc_pkg::*;

  logic           start;
  logic           busy;
  logic           done;
  logic           crd;
  logic [AW-1:0]  caddr_rd;
  logic [DW-1:0]  cdata_rd;
  logic [WAW-1:0] waddr;
  logic [DW-1:0]  wdata;
  logic           cwr;
  logic [2:0]     csel;
  logic [AW-1:0]  caddr_wr;
  logic [DW-1:0]  cdata_wr;

  modport master (
    output start, cdata_rd, wdata,
    input  busy, done, crd, caddr_rd, waddr, cwr, csel, caddr_wr, cdata_wr
  );

  modport slave (
    input  start, cdata_rd, wdata,
    output busy, done, crd, caddr_rd, waddr, cwr, csel, caddr_wr, cdata_wr
  );

endinterface

// File: rtl/fc_mac_pipe.sv
// Registered signed multiplier feeding a wide accumulator; the accumulator is
// loaded with bias << FRAC at the start of each neuron.
module fc_mac_pipe
  import fc_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    load,
  input  logic                    mul_en,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  input  logic signed [DW-1:0]    bias,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DW-1:0]  prod_q;
  logic                    prod_vld_q;
  logic signed [ACC_W-1:0] acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else if (clear) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      prod_vld_q <= mul_en;
      if (mul_en) begin
        prod_q <= (2*DW)'(a) * (2*DW)'(b);
      end
      if (load) begin
        acc_q <= {{(ACC_W-DW-FRAC){bias[DW-1]}}, bias, {FRAC{1'b0}}};
      end else if (prod_vld_q) begin
        acc_q <= acc_q + {{(ACC_W-2*DW){prod_q[2*DW-1]}}, prod_q};
      end
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer: bias + dot product per neuron over layer 5, result to layer 6.
// Define FC_RELU_EN to clamp negative results to zero.
module fc_layer_engine
  import fc_pkg::*;
#(
  parameter int unsigned N_IN  = 2048,
  parameter int unsigned N_OUT = 10
) (
  input  logic              clk,
  input  logic              reset,
  fc_layer_engine_if.slave  bus
);

  localparam logic [AW-1:0]  LastI    = AW'(N_IN - 1);
  localparam logic [AW-1:0]  LastO    = AW'(N_OUT - 1);
  localparam logic [WAW-1:0] BiasOff  = WAW'(N_IN);
  localparam logic [WAW-1:0] WStride  = WAW'(N_IN + 1);

  fc_state_e      state_q, state_d;
  logic [AW-1:0]  i_q, i_d;
  logic [AW-1:0]  o_q, o_d;
  logic [WAW-1:0] wbase_q, wbase_d;
  logic           bias_vld_q;
  logic           mul_en_q;
  logic           clear;

  logic signed [ACC_W-1:0] acc;
  logic [DW-1:0]           res_sat;
  logic [DW-1:0]           result;

  // Both read ports return data one cycle after the address, so the bias lands
  // in the first MAC cycle and each data/weight pair one cycle after its issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      i_q        <= '0;
      o_q        <= '0;
      wbase_q    <= '0;
      bias_vld_q <= 1'b0;
      mul_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      o_q        <= o_d;
      wbase_q    <= wbase_d;
      bias_vld_q <= (state_q == StBias);
      mul_en_q   <= (state_q == StMac);
    end
  end

  fc_mac_pipe u_mac (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .load   (bias_vld_q),
    .mul_en (mul_en_q),
    .a      (bus.cdata_rd),
    .b      (bus.wdata),
    .bias   (bus.wdata),
    .acc    (acc)
  );

  assign res_sat = round_sat(acc);

`ifdef FC_RELU_EN
  assign result = res_sat[DW-1] ? '0 : res_sat;
`else
  assign result = res_sat;
`endif

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    o_d          = o_q;
    wbase_d      = wbase_q;
    clear        = 1'b0;
    bus.busy     = (state_q != StIdle);
    bus.done     = 1'b0;
    bus.crd      = 1'b0;
    bus.caddr_rd = '0;
    bus.waddr    = '0;
    bus.cwr      = 1'b0;
    bus.csel     = 3'b000;
    bus.caddr_wr = '0;
    bus.cdata_wr = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StBias;
          i_d     = '0;
          o_d     = '0;
          wbase_d = '0;
          clear   = 1'b1;
        end
      end
      StBias: begin
        bus.waddr = wbase_q + BiasOff;
        state_d   = StMac;
      end
      StMac: begin
        bus.crd      = 1'b1;
        bus.csel     = CSEL_L5;
        bus.caddr_rd = i_q;
        bus.waddr    = wbase_q + WAW'(i_q);
        if (i_q == LastI) begin
          i_d     = '0;
          state_d = StDrain;
        end else begin
          i_d = i_q + AW'(1);
        end
      end
      StDrain: begin
        // Two cycles: data-return stage then product stage reach the accumulator.
        if (i_q == AW'(1)) begin
          i_d     = '0;
          state_d = StWrite;
        end else begin
          i_d = i_q + AW'(1);
        end
      end
      StWrite: begin
        bus.cwr      = 1'b1;
        bus.csel     = CSEL_L6;
        bus.caddr_wr = o_q;
        bus.cdata_wr = result;
        if (o_q == LastO) begin
          state_d = StDone;
        end else begin
          o_d     = o_q + AW'(1);
          wbase_d = wbase_q + WStride;
          state_d = StBias;
        end
      end
      StDone: begin
        bus.done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Directed bench for fc_layer_engine with N_IN=4, N_OUT=2 and behavioural memories.
module tb_fc_layer_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  fc_layer_engine_if bus ();

  fc_layer_engine #(
    .N_IN  (4),
    .N_OUT (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [19:0] lmem [4];
  logic [19:0] rom  [10];

  // One-cycle-latency layer memory and weight ROM.
  always @(posedge clk) begin
    if (bus.crd) bus.cdata_rd <= (bus.caddr_rd < 12'd4) ? lmem[bus.caddr_rd[1:0]] : 20'h0;
    bus.wdata <= (bus.waddr < 16'd10) ? rom[bus.waddr[3:0]] : 20'h0;
  end

  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          bad_rd = 0;
  int          wr_addr [64];
  logic [19:0] wr_data [64];
  int          wr_cyc  [64];
  logic [2:0]  wr_csel [64];

  always @(negedge clk) begin
    if (bus.cwr && wr_cnt < 64) begin
      wr_addr[wr_cnt] <= int'(bus.caddr_wr);
      wr_data[wr_cnt] <= bus.cdata_wr;
      wr_cyc[wr_cnt]  <= cyc;
      wr_csel[wr_cnt] <= bus.csel;
      wr_cnt          <= wr_cnt + 1;
    end
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bus.crd && bus.csel != 3'b101) bad_rd <= bad_rd + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input logic [19:0] x, input logic [19:0] w, input logic [19:0] b);
    for (int k = 0; k < 4; k++) lmem[k] = x;
    for (int k = 0; k < 10; k++) rom[k] = (k == 4 || k == 9) ? b : w;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_crd_cwr"}, {30'd0, bus.crd, bus.cwr}, 32'd0);
    chk({tag, "_csel"}, 32'(bus.csel), 32'd0);
    chk({tag, "_addrs"}, {bus.caddr_rd, bus.waddr, 4'd0} | 32'(bus.caddr_wr), 32'd0);
    chk({tag, "_cdata_wr"}, 32'(bus.cdata_wr), 32'd0);
  endtask

  // Start one job, optionally pulse start again at cycle extra_at, and check
  // writes and done timing; write k lands in cycle 8*(k+1), done in cycle 17.
  task automatic run_job(input string tag, input logic [19:0] e0, input logic [19:0] e1,
                         input int extra_at);
    int   wb;
    int   db;
    int   st;
    logic busy1;
    wb    = wr_cnt;
    db    = done_cnt;
    busy1 = 1'b0;
    @(negedge clk);
    st        = cyc;
    bus.start = 1'b1;
    for (int k = 1; k <= 40 && done_cnt == db; k++) begin
      @(negedge clk);
      if (cyc - st == 1) busy1 = bus.busy;
      bus.start = (cyc - st == extra_at) ? 1'b1 : 1'b0;
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, "_busy_c1"}, 32'(busy1), 32'd1);
    chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done_cnt"}, 32'(done_cnt - db), 32'd1);
    chk({tag, "_done_cyc"}, 32'(done_cyc - st), 32'd17);
    chk({tag, "_wr_cnt"}, 32'(wr_cnt - wb), 32'd2);
    chk({tag, "_wr0_addr"}, 32'(wr_addr[wb]), 32'd0);
    chk({tag, "_wr0_data"}, 32'(wr_data[wb]), 32'(e0));
    chk({tag, "_wr0_cyc"}, 32'(wr_cyc[wb] - st), 32'd8);
    chk({tag, "_wr0_csel"}, 32'(wr_csel[wb]), 32'd6);
    chk({tag, "_wr1_addr"}, 32'(wr_addr[wb+1]), 32'd1);
    chk({tag, "_wr1_data"}, 32'(wr_data[wb+1]), 32'(e1));
    chk({tag, "_wr1_cyc"}, 32'(wr_cyc[wb+1] - st), 32'd16);
  endtask

  logic [19:0] neg_exp;
  logic [19:0] negb_exp;
  int          wb_rst;
  int          db_rst;
  int          st_rst;

  initial begin
`ifdef FC_RELU_EN
    neg_exp  = 20'h00000;
    negb_exp = 20'h00000;
`else
    neg_exp  = 20'hC0000;
    negb_exp = 20'hFFFFF;
`endif
    bus.start = 1'b0;
    set_mem(20'h0, 20'h0, 20'h0);
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset_hold");
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("reset_rel");

    set_mem(20'h10000, 20'h08000, 20'h00000);
    run_job("half_weights", 20'h20000, 20'h20000, 0);

    set_mem(20'h10000, 20'hF0000, 20'h00000);
    run_job("neg_weights", neg_exp, neg_exp, 0);

    set_mem(20'h7FFFF, 20'h7FFFF, 20'h7FFFF);
    run_job("pos_sat", 20'h7FFFF, 20'h7FFFF, 0);

    set_mem(20'h0, 20'h0, 20'h0);
    lmem[0] = 20'h00001;
    rom[0]  = 20'h08000;
    run_job("round_half", 20'h00001, 20'h00000, 0);

    set_mem(20'h0, 20'h0, 20'h0);
    rom[4] = 20'h18000;
    rom[9] = 20'hFFFFF;
    run_job("bias_only", 20'h18000, negb_exp, 0);

    set_mem(20'h10000, 20'h08000, 20'h00000);
    run_job("double_start", 20'h20000, 20'h20000, 5);

    // Abort in the middle of neuron 0's MAC phase.
    wb_rst = wr_cnt;
    db_rst = done_cnt;
    @(negedge clk);
    st_rst    = cyc;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc - st_rst < 3) @(negedge clk);
    chk("mid_run_crd", 32'(bus.crd), 32'd1);
    reset = 1'b1;
    #1;
    chk_idle_outputs("abort");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_wr", 32'(wr_cnt - wb_rst), 32'd0);
    chk("abort_no_done", 32'(done_cnt - db_rst), 32'd0);
    chk("abort_idle", 32'(bus.busy), 32'd0);

    run_job("after_abort", 20'h20000, 20'h20000, 0);
    chk("rd_csel", 32'(bad_rd), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
